// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives a comparator probe MSB-first
// and resolves the unknown operand. Optional macro SAR_CMP_CHECK_EN aborts on non-one-hot flags.
module sar_search_ctrl #(
    parameter  int WIDTH   = 3,
    localparam int STEPS_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cmp_eq,
    input  logic               cmp_gt,
    input  logic               cmp_lt,
    output logic [WIDTH-1:0]   probe,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [WIDTH-1:0]   result,
    output logic [STEPS_W-1:0] steps,
    output logic               err
);

    typedef enum logic {IDLE, SEARCH} state_t;

    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

    state_t             state, state_n;
    logic [WIDTH-1:0]   bit_sel, bit_sel_n;   // one-hot marker of the bit under test
    logic [WIDTH-1:0]   probe_n, result_n, probe_adj;
    logic [STEPS_W-1:0] steps_n;
    logic               done_n, found_n, err_n;
    logic               flag_fault;

`ifdef SAR_CMP_CHECK_EN
    assign flag_fault = !$onehot({cmp_eq, cmp_gt, cmp_lt});
`else
    assign flag_fault = 1'b0;
`endif

    assign busy = (state == SEARCH);

    // gt keeps the tested bit; lt, and all-zero flags, clear it.
    always_comb begin
        probe_adj = probe & ~bit_sel;
        casez ({cmp_gt, cmp_lt})
            2'b1?:   probe_adj = probe | bit_sel;
            2'b01:   probe_adj = probe & ~bit_sel;
            default: probe_adj = probe & ~bit_sel;
        endcase
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_n   = state;
        probe_n   = probe;
        bit_sel_n = bit_sel;
        result_n  = result;
        steps_n   = steps;
        done_n    = 1'b0;
        found_n   = found;
        err_n     = err;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SEARCH;
                    probe_n   = MSB;
                    bit_sel_n = MSB;
                    steps_n   = '0;
                    found_n   = 1'b0;
                    err_n     = 1'b0;
                end
            end
            SEARCH: begin
                steps_n = steps + STEPS_W'(1);
                if (flag_fault) begin
                    err_n    = 1'b1;
                    done_n   = 1'b1;
                    found_n  = 1'b0;
                    result_n = '0;
                    probe_n  = '0;
                    state_n  = IDLE;
                end else if (cmp_eq) begin
                    result_n = probe;
                    found_n  = 1'b1;
                    done_n   = 1'b1;
                    probe_n  = '0;
                    state_n  = IDLE;
                end else if (bit_sel[0]) begin
                    result_n = probe_adj;
                    found_n  = 1'b0;
                    done_n   = 1'b1;
                    probe_n  = '0;
                    state_n  = IDLE;
                end else begin
                    probe_n   = probe_adj | (bit_sel >> 1);
                    bit_sel_n = bit_sel >> 1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            probe   <= '0;
            bit_sel <= '0;
            result  <= '0;
            steps   <= '0;
            done    <= 1'b0;
            found   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            probe   <= probe_n;
            bit_sel <= bit_sel_n;
            result  <= result_n;
            steps   <= steps_n;
            done    <= done_n;
            found   <= found_n;
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: behavioural comparator plus a binary-search
// reference model; directed scenarios followed by randomized operands.
module tb_sar_search_ctrl;

    localparam int WIDTH   = 3;
    localparam int STEPS_W = $clog2(WIDTH + 1);

    logic               clk = 1'b0;
    logic               rst, start;
    logic               cmp_eq, cmp_gt, cmp_lt;
    logic [WIDTH-1:0]   probe, result;
    logic               busy, done, found, err;
    logic [STEPS_W-1:0] steps;

    int       a_val     = 0;
    bit       ovr_en    = 1'b0;
    logic [2:0] ovr_flags = 3'b000;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_probes[$];
    int exp_result;
    bit exp_found;

    sar_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_eq (cmp_eq),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result),
        .steps  (steps),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Comparator model: A is a_val, B is the probe; override lets a test inject bad flags.
    always_comb begin
        cmp_eq = (a_val == int'(probe));
        cmp_gt = (a_val >  int'(probe));
        cmp_lt = (a_val <  int'(probe));
        if (ovr_en) {cmp_eq, cmp_gt, cmp_lt} = ovr_flags;
    end

    // Reference: halve the interval MSB-first, probing prefix + 2^k.
    task automatic build_model(input int a);
        int prefix = 0;
        int p;
        exp_probes.delete();
        exp_found = 1'b0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            p = prefix + (1 << k);
            exp_probes.push_back(p);
            if (p == a) begin
                exp_found = 1'b1;
                break;
            end
            if (a > p) prefix = p;
        end
        exp_result = exp_found ? a : prefix;
    endtask

    task automatic run_search(input int a, input bit pre_started, input bit hold_start,
                              input bit chain, input int next_a);
        int got[$];
        bit seen_done = 1'b0;
        build_model(a);
        if (!pre_started) begin
            @(negedge clk);
            a_val = a;
            start = 1'b1;
        end
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        for (int c = 0; c < WIDTH + 2; c++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (busy) got.push_back(int'(probe));
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL done_timeout a=%0d: done not seen within %0d cycles", a, WIDTH + 2);
        end
        n_checks++;
        if (got.size() !== exp_probes.size()) begin
            n_fail++;
            $display("FAIL probe_count a=%0d: got %0d compares, expected %0d", a, got.size(), exp_probes.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                n_checks++;
                if (got[i] !== exp_probes[i]) begin
                    n_fail++;
                    $display("FAIL probe_seq a=%0d step %0d: got %0d expected %0d", a, i, got[i], exp_probes[i]);
                end
            end
        end
        n_checks++;
        if (int'(result) !== exp_result) begin
            n_fail++;
            $display("FAIL result a=%0d: got %0d expected %0d", a, result, exp_result);
        end
        n_checks++;
        if (found !== exp_found) begin
            n_fail++;
            $display("FAIL found a=%0d: got %0b expected %0b", a, found, exp_found);
        end
        n_checks++;
        if (int'(steps) !== exp_probes.size()) begin
            n_fail++;
            $display("FAIL steps a=%0d: got %0d expected %0d", a, steps, exp_probes.size());
        end
        n_checks++;
        if ({busy, err, probe} !== {2'b00, WIDTH'(0)}) begin
            n_fail++;
            $display("FAIL done_state a=%0d: busy=%0b err=%0b probe=%0d expected 0,0,0", a, busy, err, probe);
        end
        if (chain) begin
            a_val = next_a;
            start = 1'b1;
        end else begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse a=%0d: done still %0b one cycle later, expected 0", a, done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({probe, busy, done, found, result, steps, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: probe=%0d busy=%0b done=%0b found=%0b result=%0d steps=%0d err=%0b expected all 0",
                     probe, busy, done, found, result, steps, err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%0b done=%0b expected 0,0", busy, done);
        end
    endtask

    task automatic test_directed();
        run_search(5, 1'b0, 1'b0, 1'b0, 0);
        run_search(4, 1'b0, 1'b0, 1'b0, 0);
        run_search(0, 1'b0, 1'b0, 1'b0, 0);
        run_search(5, 1'b0, 1'b1, 1'b0, 0);  // start held high while busy
    endtask

    task automatic test_back_to_back();
        run_search(7, 1'b0, 1'b0, 1'b1, 3);
        run_search(3, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_search();
        @(negedge clk);
        a_val = 6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (int'(probe) !== 4) begin
            n_fail++;
            $display("FAIL mid_reset_probe1: got %0d expected 4", probe);
        end
        @(negedge clk);
        n_checks++;
        if (int'(probe) !== 6) begin
            n_fail++;
            $display("FAIL mid_reset_probe2: got %0d expected 6", probe);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({probe, busy, done, found, result, steps, err} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_state: probe=%0d busy=%0b done=%0b found=%0b result=%0d steps=%0d err=%0b expected all 0",
                     probe, busy, done, found, result, steps, err);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_no_done: busy=%0b done=%0b expected 0,0", busy, done);
        end
        run_search(6, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_flag_fault();
        @(negedge clk);
        a_val = 6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ovr_en = 1'b1;
        ovr_flags = 3'b011;
        @(negedge clk);
        ovr_en = 1'b0;
`ifdef SAR_CMP_CHECK_EN
        n_checks++;
        if ({done, err, found, busy} !== 4'b1100 || result !== '0) begin
            n_fail++;
            $display("FAIL fault_abort: done=%0b err=%0b found=%0b busy=%0b result=%0d expected 1,1,0,0,0",
                     done, err, found, busy, result);
        end
        @(negedge clk);
        n_checks++;
        if ({done, err} !== 2'b01) begin
            n_fail++;
            $display("FAIL fault_hold: done=%0b err=%0b expected 0,1", done, err);
        end
        run_search(2, 1'b0, 1'b0, 1'b0, 0);  // new start clears err
`else
        n_checks++;
        if ({err, busy, done} !== 3'b010 || int'(probe) !== 6) begin
            n_fail++;
            $display("FAIL fault_as_gt: err=%0b busy=%0b done=%0b probe=%0d expected 0,1,0,6", err, busy, done, probe);
        end
        @(negedge clk);
        n_checks++;
        if ({done, found, err} !== 3'b110 || int'(result) !== 6 || int'(steps) !== 2) begin
            n_fail++;
            $display("FAIL fault_as_gt_done: done=%0b found=%0b err=%0b result=%0d steps=%0d expected 1,1,0,6,2",
                     done, found, err, result, steps);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_random();
        bit pend = 1'b0;
        int cur  = 0;
        int nxt;
        bit ch;
        for (int i = 0; i < 24; i++) begin
            if (!pend) cur = int'($urandom_range(0, (1 << WIDTH) - 1));
            nxt = int'($urandom_range(0, (1 << WIDTH) - 1));
            ch  = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_search(cur, pend, 1'($urandom_range(0, 1)), ch, nxt);
            pend = ch;
            cur  = nxt;
            if (!ch) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_search();
        test_flag_fault();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller: the initiating end of the 3-bit magnitude comparator interface.
- Drives the comparator's B operand (probe) and reads back the equal/greater/less flags for an unknown A on the comparator's other input.
- Resolves A MSB-first in at most WIDTH cycles, with early exit on equality.
- Used to recover/digitise a value that is only observable through compare results.

Parameters:
- WIDTH, 3, operand width; must match the comparator width, minimum 1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a search; sampled only in IDLE
- cmp_eq  input  1  comparator A_equal_B for the current probe
- cmp_gt  input  1  comparator A_greater_B for the current probe
- cmp_lt  input  1  comparator A_less_B for the current probe
- probe  output  WIDTH  registered value driven to comparator B
- busy  output  1  high while in SEARCH
- done  output  1  one-cycle pulse when result is valid
- found  output  1  high with done if termination was via cmp_eq
- result  output  WIDTH  resolved A; held until the next start
- steps  output  $clog2(WIDTH+1)  compare cycles consumed by the last search
- err  output  1  comparator flag fault (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; probe, busy, done, found, result, steps and err all 0. Applies mid-search too: abort with no done pulse.
- The comparator is combinational. Flags are valid in the same cycle as the registered probe and are evaluated at the next clock edge.
- States: IDLE, SEARCH.
- IDLE, start=1:
  - go to SEARCH; bit index i=WIDTH-1; probe=1<<(WIDTH-1); steps=0.
  - clear found and err.
  - result keeps its old value until completion.
- SEARCH, each edge: steps+=1, then decision priority eq > gt > lt:
  - cmp_eq: result=probe, found=1, done=1, go to IDLE.
  - cmp_gt: keep bit i of probe.
  - otherwise (lt): clear bit i of probe.
  - If not terminated and i==0: result=adjusted probe, found=0, done=1, go to IDLE.
  - Else: set bit i-1 in probe, i-=1.
- Latency from start to done: 1..WIDTH+1 edges (1 for IDLE->SEARCH plus 1..WIDTH compares). Only A=0 ends without eq.
- probe returns to 0 on entering IDLE.
- done asserts for exactly one cycle. busy drops on the same edge that asserts done.
- start while busy: ignored. start on the done cycle: accepted (state is IDLE).
- steps holds its final value until the next start.
- WIDTH=1: a single compare of probe=1.

Optional Feature:
- Macro: SAR_CMP_CHECK_EN.
- Defined: in SEARCH, if {cmp_eq,cmp_gt,cmp_lt} is not exactly one-hot, the search aborts:
  - err=1, done=1, found=0, result=0, go to IDLE.
  - err holds until the next start or rst.
- Not defined: err is tied to 0; the priority rules above apply, and all-zero flags are treated as lt.

Test Plan:
- WIDTH=3, model comparator with A=5, pulse start -> probes 4,6,5; done on 3rd compare edge; result=5, found=1, steps=3.
- A=4 -> probe 4 only; done after 1 compare; result=4, found=1, steps=1.
- A=0 -> probes 4,2,1; done after 3 compares; result=0, found=0, steps=3.
- A=7 then A=3 back-to-back, start asserted on the done cycle -> second search starts immediately; probes 4,6,7 then 4,2,3; results 7 then 3.
- rst asserted at the 2nd compare of A=6 -> next cycle all outputs 0, no done pulse; start afterwards -> result=6.
- With SAR_CMP_CHECK_EN defined, force cmp_gt=cmp_lt=1 on the first compare -> done=1, err=1, result=0. Without the macro -> err=0 and the search proceeds as gt.
